// File: rtl/axi_r_allocator_rr.sv
// axi_r_allocator_rr: round-robin R-channel merger with burst lock, outstanding counter and DECERR injection
// Ports: clk/rst_n (async active-low reset); r*_i[N] per-source R channels, rready_o[N] per-source ready;
// r*_o/rready_i merged R channel; incr_req_i counts issued bursts, full_counter_o/outstanding_trans_o report it;
// error_req_i/error_ready_o push {error_len_i, error_id_i, error_user_i}; error_done_o marks the last error beat.
module axi_r_allocator_rr #(
   parameter int          AXI_USER_W  = 6,
   parameter int          N_INIT_PORT = 4,
   parameter int          AXI_DATA_W  = 64,
   parameter int          AXI_ID_IN   = 16,
   parameter int          AXI_ID_OUT  = AXI_ID_IN + 3,
   parameter int          CNT_W       = 10,
   parameter int          ERR_DEPTH   = 2,
   parameter logic [31:0] ERR_PATTERN = 32'hDEADBEEF
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [N_INIT_PORT*AXI_ID_OUT-1:0]   rid_i,
   input  logic [N_INIT_PORT*AXI_DATA_W-1:0]   rdata_i,
   input  logic [N_INIT_PORT*2-1:0]            rresp_i,
   input  logic [N_INIT_PORT-1:0]              rlast_i,
   input  logic [N_INIT_PORT*AXI_USER_W-1:0]   ruser_i,
   input  logic [N_INIT_PORT-1:0]              rvalid_i,
   output logic [N_INIT_PORT-1:0]              rready_o,
   output logic [AXI_ID_IN-1:0]                rid_o,
   output logic [AXI_DATA_W-1:0]               rdata_o,
   output logic [1:0]                          rresp_o,
   output logic                                rlast_o,
   output logic [AXI_USER_W-1:0]               ruser_o,
   output logic                                rvalid_o,
   input  logic                                rready_i,
   input  logic                                incr_req_i,
   output logic                                full_counter_o,
   output logic                                outstanding_trans_o,
   input  logic                                error_req_i,
   output logic                                error_ready_o,
   input  logic [7:0]                          error_len_i,
   input  logic [AXI_ID_IN-1:0]                error_id_i,
   input  logic [AXI_USER_W-1:0]               error_user_i,
   output logic                                error_done_o
);
   localparam int N  = N_INIT_PORT;
   localparam int PW = N > 1 ? $clog2(N) : 1;
   localparam int AW = ERR_DEPTH > 1 ? $clog2(ERR_DEPTH) : 1;
   localparam int EW = 8 + AXI_ID_IN + AXI_USER_W;
   typedef enum logic [1:0] {OPERATIVE, DRAIN, ERR} state_t;
   state_t                state;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [PW-1:0]         rr_ptr, lock_src, win, j;
   logic                  lock, found, is_err, acc, decr, push, pop, fifo_full, fifo_empty;
   logic [7:0]            beat, head_len;
   logic [EW-1:0]         mem [ERR_DEPTH];
   logic [EW-1:0]         head;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           fcnt, fcnt_nxt;
   logic [AXI_ID_IN-1:0]  head_id;
   logic [AXI_USER_W-1:0] head_user;
   logic                  unused_ok;
   assign unused_ok  = ^rid_i;
   assign is_err     = state == ERR;
   assign head       = mem[rd_ptr];
   assign head_len   = head[EW-1 -: 8];
   assign head_id    = head[AXI_USER_W +: AXI_ID_IN];
   assign head_user  = head[AXI_USER_W-1:0];
   assign fifo_full  = fcnt == (AW+1)'(ERR_DEPTH);
   assign fifo_empty = fcnt == '0;
   assign error_ready_o = !fifo_full;
   assign push       = error_req_i & !fifo_full;
   assign error_done_o = is_err & rready_i & (beat == head_len);
   assign pop        = error_done_o;
   assign fcnt_nxt   = fcnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   assign acc        = rvalid_o & rready_i & !is_err;
   assign decr       = acc & rlast_o;
   assign cnt_nxt    = (incr_req_i & !decr & !(&cnt)) ? cnt + 1'b1 :
                       (decr & !incr_req_i & (|cnt)) ? cnt - 1'b1 : cnt;
   assign full_counter_o      = &cnt;
   assign outstanding_trans_o = |cnt;
   // A locked burst keeps its source even while it idles; a single source is always granted.
   always_comb begin
      win   = lock_src;
      found = (N == 1) | lock;
      j     = '0;
      if (!found)
         for (int k = 0; k < N; k++) begin
            j = PW'((int'(rr_ptr) + k) % N);
            if (!found && rvalid_i[j]) begin
               found = 1'b1;
               win   = j;
            end
         end
   end
   always_comb begin
      rready_o = '0;
      if (found && !is_err) rready_o[win] = rready_i;
      rvalid_o = is_err | (found & rvalid_i[win]);
      rid_o    = is_err ? head_id : rid_i[win*AXI_ID_OUT +: AXI_ID_IN];
      rdata_o  = is_err ? {(AXI_DATA_W/32){ERR_PATTERN}} : rdata_i[win*AXI_DATA_W +: AXI_DATA_W];
      rresp_o  = is_err ? 2'b11 : rresp_i[win*2 +: 2];
      rlast_o  = is_err ? beat == head_len : rlast_i[win];
      ruser_o  = is_err ? head_user : ruser_i[win*AXI_USER_W +: AXI_USER_W];
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {error_len_i, error_id_i, error_user_i};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= OPERATIVE;
         cnt      <= '0;
         rr_ptr   <= '0;
         lock     <= 1'b0;
         lock_src <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fcnt     <= '0;
         beat     <= '0;
      end else begin
         cnt  <= cnt_nxt;
         fcnt <= fcnt_nxt;
         if (push) wr_ptr <= (wr_ptr == AW'(ERR_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= (rd_ptr == AW'(ERR_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         if (acc && N > 1) begin
            if (rlast_o) begin
               lock   <= 1'b0;
               rr_ptr <= (win == PW'(N-1)) ? '0 : win + 1'b1;
            end else begin
               lock     <= 1'b1;
               lock_src <= win;
            end
         end
         case (state)
            OPERATIVE:
               if (!fifo_empty) begin
                  state <= (|cnt || lock) ? DRAIN : ERR;
                  beat  <= '0;
               end
            DRAIN:
               if (!(|cnt) && !lock) begin
                  state <= ERR;
                  beat  <= '0;
               end
            ERR:
               if (rready_i) begin
                  if (error_done_o) begin
                     beat  <= '0;
                     // Back-to-back errors only when nothing is outstanding any more.
                     state <= (fcnt_nxt != '0 && cnt_nxt == '0 && !lock) ? ERR : OPERATIVE;
                  end else
                     beat <= beat + 1'b1;
               end
            default: state <= OPERATIVE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_r_allocator_rr.sv
// tb_axi_r_allocator_rr: randomized and directed checks against a queue-based reference model
module tb_axi_r_allocator_rr;
   logic        clk = 0, rst_n = 0;
   logic [75:0] rid_i;
   logic [255:0] rdata_i;
   logic [7:0]  rresp_i;
   logic [3:0]  rlast_i, rvalid_i, rready_o;
   logic [23:0] ruser_i;
   logic [15:0] rid_o;
   logic [63:0] rdata_o;
   logic [1:0]  rresp_o;
   logic        rlast_o, rvalid_o, rready_i, incr_req_i, full_counter_o, outstanding_trans_o;
   logic [5:0]  ruser_o;
   logic        error_req_i, error_ready_o, error_done_o;
   logic [7:0]  error_len_i;
   logic [15:0] error_id_i;
   logic [5:0]  error_user_i;
   int total = 0, bad = 0;
   typedef struct {logic [7:0] len; logic [15:0] id; logic [5:0] user;} err_t;
   err_t m_q[$];
   int m_cnt, m_ptr, m_lsrc, m_mode, m_beat;
   bit m_lock;
   axi_r_allocator_rr dut (
      .clk(clk), .rst_n(rst_n), .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
      .rlast_i(rlast_i), .ruser_i(ruser_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
      .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .ruser_o(ruser_o),
      .rvalid_o(rvalid_o), .rready_i(rready_i), .incr_req_i(incr_req_i),
      .full_counter_o(full_counter_o), .outstanding_trans_o(outstanding_trans_o),
      .error_req_i(error_req_i), .error_ready_o(error_ready_o), .error_len_i(error_len_i),
      .error_id_i(error_id_i), .error_user_i(error_user_i), .error_done_o(error_done_o));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic idle();
      rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = '0; ruser_i = '0; rvalid_i = '0;
      rready_i = 0; incr_req_i = 0; error_req_i = 0; error_len_i = '0; error_id_i = '0; error_user_i = '0;
   endtask
   task automatic do_reset();
      rst_n = 0;
      idle();
      #1;
      check("rst_rvalid", rvalid_o, 0);
      check("rst_rready", rready_o, 0);
      check("rst_full", full_counter_o, 0);
      check("rst_outst", outstanding_trans_o, 0);
      check("rst_err_ready", error_ready_o, 1);
      check("rst_done", error_done_o, 0);
      m_cnt = 0; m_ptr = 0; m_lsrc = 0; m_mode = 0; m_beat = 0; m_lock = 0;
      m_q.delete();
      @(posedge clk); #1;
      rst_n = 1;
   endtask
   // One cycle: compare DUT against the model, then advance the model to the next edge.
   task automatic step();
      int w, n_cnt, qa;
      bit any, e_v, e_last, e_done, acc, decr, push, pop;
      logic [3:0] e_rdy;
      logic [63:0] e_data;
      logic [15:0] e_id;
      logic [5:0] e_user;
      logic [1:0] e_resp;
      #2;
      w = m_lsrc; any = m_lock; e_done = 0;
      if (m_mode == 2) begin
         e_v = 1; e_resp = 2'b11; e_data = {2{32'hDEADBEEF}}; e_id = m_q[0].id; e_user = m_q[0].user;
         e_last = (m_beat == int'(m_q[0].len)); e_rdy = 0; e_done = rready_i && e_last;
      end else begin
         if (!m_lock)
            for (int k = 0; k < 4; k++)
               if (!any && rvalid_i[(m_ptr + k) % 4]) begin any = 1; w = (m_ptr + k) % 4; end
         e_v = any && rvalid_i[w];
         e_rdy = any ? 4'(rready_i) << w : 4'b0;
         e_id = rid_i[w*19 +: 16]; e_data = rdata_i[w*64 +: 64]; e_resp = rresp_i[w*2 +: 2];
         e_last = rlast_i[w]; e_user = ruser_i[w*6 +: 6];
      end
      check("rvalid", rvalid_o, e_v);
      if (e_v) begin
         check("rid", rid_o, e_id);
         check("rdata", rdata_o, e_data);
         check("rresp", rresp_o, e_resp);
         check("rlast", rlast_o, e_last);
         check("ruser", ruser_o, e_user);
      end
      check("rready_o", rready_o, e_rdy);
      check("err_done", error_done_o, e_done);
      check("full", full_counter_o, m_cnt == 1023);
      check("outst", outstanding_trans_o, m_cnt != 0);
      check("err_ready", error_ready_o, m_q.size() < 2);
      acc = e_v && rready_i;
      decr = m_mode != 2 && acc && e_last;
      n_cnt = m_cnt;
      if (incr_req_i && !decr && m_cnt < 1023) n_cnt++;
      if (decr && !incr_req_i && m_cnt > 0) n_cnt--;
      push = error_req_i && m_q.size() < 2;
      pop = e_done;
      qa = m_q.size() - int'(pop) + int'(push);
      case (m_mode)
         0: if (m_q.size() > 0) begin m_mode = (m_cnt != 0 || m_lock) ? 1 : 2; m_beat = 0; end
         1: if (m_cnt == 0 && !m_lock) begin m_mode = 2; m_beat = 0; end
         default:
            if (rready_i) begin
               if (e_last) begin m_beat = 0; m_mode = (qa > 0 && n_cnt == 0 && !m_lock) ? 2 : 0; end
               else m_beat++;
            end
      endcase
      if (e_v && rready_i && !(e_id === m_q[0].id && m_mode == 2 && 0)) ;
      if (acc && e_rdy != 0) begin
         if (e_last) begin m_lock = 0; m_ptr = (w + 1) % 4; end
         else begin m_lock = 1; m_lsrc = w; end
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back('{error_len_i, error_id_i, error_user_i});
      m_cnt = n_cnt;
      @(posedge clk); #1;
   endtask
   initial begin
      logic [3:0] g [5];
      logic [15:0] ids [$];
      int nb, dones, lastat;
      g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      rvalid_i = 4'hf; rlast_i = 4'hf; rready_i = 1;
      for (int i = 0; i < 5; i++) begin #1; check("rr_grant", rready_o, g[i]); step(); end
      rvalid_i = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         rlast_i = {2'b00, i == 3, 1'b1};
         #1; check("burst_lock", rready_o, 4'b0010); step();
      end
      rvalid_i = 4'hf; rlast_i = 4'hf;
      #1; check("ptr_after_burst", rready_o, 4'b0100); step();
      do_reset();
      incr_req_i = 1;
      repeat (3) step();
      incr_req_i = 0; error_req_i = 1; error_len_i = 2; error_id_i = 16'h3c; error_user_i = 5;
      step();
      error_req_i = 0;
      repeat (2) begin #1; check("drain_hold", rvalid_o, 0); step(); end
      rvalid_i = 1; rlast_i = 1; rready_i = 1;
      repeat (3) step();
      rvalid_i = 0;
      nb = 0; dones = 0; lastat = 0;
      repeat (8) begin
         #1;
         if (rvalid_o && rresp_o == 2'b11) begin
            nb++;
            if (nb == 1) check("err_data", rdata_o, 64'hDEADBEEFDEADBEEF);
            if (rlast_o) lastat = nb;
         end
         dones += int'(error_done_o);
         step();
      end
      check("err_beats", nb, 3);
      check("err_dones", dones, 1);
      check("err_last_at", lastat, 3);
      do_reset();
      incr_req_i = 1;
      repeat (1029) step();
      #1; check("saturate", full_counter_o, 1);
      rvalid_i = 1; rlast_i = 1; rready_i = 1;
      step();
      #1; check("incr_decr_hold", full_counter_o, 1);
      incr_req_i = 0;
      step();
      #1; check("decr_from_full", full_counter_o, 0);
      do_reset();
      error_req_i = 1; error_len_i = 1; error_id_i = 16'h11;
      step();
      error_len_i = 0; error_id_i = 16'h22;
      step();
      error_req_i = 0;
      #1; check("fifo_full_ready", error_ready_o, 0);
      check("err_first_id", rid_o, 16'h11);
      rready_i = 1;
      repeat (5) begin
         #1; if (rvalid_o && rresp_o == 2'b11) ids.push_back(rid_o);
         step();
      end
      check("err_order_n", ids.size(), 3);
      if (ids.size() == 3) begin
         check("err_order0", ids[0], 16'h11);
         check("err_order1", ids[1], 16'h11);
         check("err_order2", ids[2], 16'h22);
      end
      do_reset();
      error_req_i = 1; error_len_i = 3; error_id_i = 16'h77;
      step();
      error_req_i = 0;
      step();
      rready_i = 1;
      step();
      #1; check("err_mid_burst", rvalid_o, 1);
      do_reset();
      repeat (2000) begin
         rvalid_i = 4'($urandom); rlast_i = 4'($urandom);
         rid_i = 76'({$urandom, $urandom, $urandom});
         for (int k = 0; k < 8; k++) rdata_i[k*32 +: 32] = $urandom;
         rresp_i = 8'($urandom); ruser_i = 24'($urandom);
         rready_i = ($urandom % 4) != 0; incr_req_i = ($urandom % 4) == 0;
         error_req_i = ($urandom % 8) == 0; error_len_i = 8'($urandom % 4);
         error_id_i = 16'($urandom); error_user_i = 6'($urandom);
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/axi_r_allocator_rr.md
AXI_R_ALLOCATOR_RR -- requirements
Module: axi_r_allocator_rr

Interface
REQ-001 Parameter AXI_USER_W, default 6, width of the R-channel user field.
REQ-002 Parameter N_INIT_PORT, default 4, number of R-channel sources; values 1..16 are legal.
REQ-003 Parameter AXI_DATA_W, default 64, R data width; it SHALL be a multiple of 32.
REQ-004 Parameter AXI_ID_IN, default 16, width of the output ID.
REQ-005 Parameter AXI_ID_OUT, default AXI_ID_IN+3, width of the input ID; only bits [AXI_ID_IN-1:0] are forwarded.
REQ-006 Parameter CNT_W, default 10, outstanding-counter width.
REQ-007 Parameter ERR_DEPTH, default 2, depth of the error-request FIFO (power of two, at least 1).
REQ-008 Parameter ERR_PATTERN, default 32'hDEADBEEF, 32-bit word replicated across error data.
REQ-009 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-010 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-011 Ports rid_i [N][AXI_ID_OUT], rdata_i [N][AXI_DATA_W], rresp_i [N][2], rlast_i [N], ruser_i [N][AXI_USER_W], rvalid_i [N]: inputs, the per-source R channels.
REQ-012 Port rready_o, output, N bits: per-source ready.
REQ-013 Ports rid_o [AXI_ID_IN], rdata_o, rresp_o, rlast_o, ruser_o, rvalid_o: outputs, the merged R channel; rready_i is its 1-bit ready input.
REQ-014 Port incr_req_i, input, 1 bit: one read burst issued downstream.
REQ-015 Ports full_counter_o and outstanding_trans_o: outputs, 1 bit each; full_counter_o means the counter is all-ones, outstanding_trans_o means the counter is non-zero.
REQ-016 Ports error_req_i (input, 1 bit), error_ready_o (output, 1 bit), error_len_i [8], error_id_i [AXI_ID_IN], error_user_i [AXI_USER_W]: the error-push handshake and its payload.
REQ-017 Port error_done_o, output, 1 bit: pulses on the final error beat handshake.

Function
REQ-018 Counter: +1 on incr_req_i alone, -1 on decr alone, hold on both or neither; it saturates at all-ones and at 0.
REQ-019 decr is the accepted source beat with rlast: rvalid_o & rready_i & rlast_o while the selected output comes from a source.
REQ-020 Arbitration is round-robin starting from pointer rr_ptr; the winner is the first i at or after rr_ptr with rvalid_i[i] set.
REQ-021 Burst lock: once a non-last beat of a source is accepted, grant stays on that source until its rlast beat is accepted.
REQ-022 After an rlast beat from source k is accepted, rr_ptr becomes (k+1) mod N; otherwise rr_ptr holds.
REQ-023 Forwarding is zero-latency and combinational from the winner's fields to the output, and rready_o[winner] = rready_i.
REQ-024 All other rready_o bits are 0.
REQ-025 When N_INIT_PORT = 1, the single source is passed straight through with no lock or pointer logic.
REQ-026 Error FIFO: a push happens on error_req_i & error_ready_o, and error_ready_o = !fifo_full.
REQ-027 Each FIFO entry holds {len, id, user}.
REQ-028 FSM states: OPERATIVE, DRAIN, ERR.
REQ-029 OPERATIVE -> DRAIN when the FIFO is non-empty and (counter != 0 or the lock is active).
REQ-030 OPERATIVE -> ERR when the FIFO is non-empty, the counter is 0 and the lock is inactive.
REQ-031 DRAIN -> ERR when the counter is 0 and the lock is inactive; otherwise DRAIN holds.
REQ-032 In DRAIN, source forwarding continues normally.
REQ-033 In ERR, rready_o = 0 for all sources, rvalid_o = 1, rresp_o = 2'b11 (DECERR), and rdata_o = ERR_PATTERN replicated AXI_DATA_W/32 times.
REQ-034 In ERR, rid_o and ruser_o come from the FIFO head.
REQ-035 ERR emits len+1 beats and uses an 8-bit beat counter, cleared on entry and advanced on each rready_i.
REQ-036 rlast_o = 1 in ERR exactly when beat counter == len.
REQ-037 On the last error beat handshake: the FIFO pops, error_done_o = 1 for that cycle, and the beat counter clears.
REQ-038 After that handshake the FSM moves to ERR if the FIFO stays non-empty and counter = 0, otherwise to OPERATIVE.
REQ-039 A push and a pop in the same cycle are both honoured, and the FIFO occupancy holds.
REQ-040 incr_req_i during DRAIN or ERR still updates the counter.
REQ-041 A non-zero counter after ERR sends the FSM through DRAIN before the next error.
REQ-042 Error beats do not alter the counter or rr_ptr.

Reset
REQ-043 While rst_n = 0, asynchronously: counter = 0, FSM = OPERATIVE, rr_ptr = 0, lock cleared, FIFO empty, beat counter = 0.
REQ-044 Outputs under reset: full_counter_o = 0, outstanding_trans_o = 0, error_ready_o = 1, error_done_o = 0, rvalid_o = 0 with all rvalid_i low.
REQ-045 Reset in the middle of a burst or an error burst abandons it; no partial state survives.

Verification
REQ-046 N=4, rvalid_i = 4'b1111, single-beat bursts, rready_i = 1 -> grants go 0,1,2,3,0 on consecutive cycles.
REQ-047 Source 1 sends a 4-beat burst while source 0 stays valid -> all 4 beats come from source 1 before any source-0 beat; rr_ptr = 2 afterwards.
REQ-048 Counter = 3, error push len = 2 -> DRAIN until 3 rlast beats are accepted, then 3 DECERR beats of 64'hDEADBEEFDEADBEEF with rlast on the 3rd and error_done_o pulsing once.
REQ-049 incr_req_i for 2^CNT_W+5 cycles with no decr -> counter saturates and full_counter_o = 1; simultaneous incr and decr -> counter unchanged.
REQ-050 Two error pushes back-to-back with ERR_DEPTH = 2 -> error_ready_o = 0 after the second push; both error bursts are issued in order.
REQ-051 rst_n asserted during the beat counter = 1 of a len = 3 error -> all outputs return to reset values immediately.
